// File: rtl/step_sequencer_if.sv
// step_sequencer_if: run-control command / status bundle for step_sequencer.
//   rst     controller -> sequencer  soft clear command
//   en      controller -> sequencer  advance enable
//   count   sequencer -> controller  current step value (CNT_W bits)
//   tick    sequencer -> controller  one-cycle pulse per step
//   wrap    sequencer -> controller  one-cycle pulse on MAX->0 (or arrival at MAX when saturating)
//   running sequencer -> controller  phase == RUN
//   paused  sequencer -> controller  phase == PAUSE
// Modports: master (run-control side), slave (sequencer side).
interface step_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             wrap;
  logic             running;
  logic             paused;

  modport master (
    output rst, en,
    input  count, tick, wrap, running, paused
  );

  modport slave (
    input  rst, en,
    output count, tick, wrap, running, paused
  );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: prescaled step counter driven by the run-control rst/en pair.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (overrides everything)
//   bus    step_sequencer_if.slave: rst/en in; count/tick/wrap/running/paused out
// Parameters: CNT_W counter width, MAX terminal count (1..2^CNT_W-1),
//   DIV enabled cycles per step (>=1).
// Optional feature macro STEP_SEQUENCER_SATURATE_EN: count holds at MAX
//   instead of wrapping; wrap pulses on the first arrival at MAX.
module step_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MAX   = 255,
  parameter int unsigned DIV   = 4
) (
  input  logic           clk,
  input  logic           reset,
  step_sequencer_if.slave bus
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } phase_t;

  phase_t           r_phase;
  logic [PW-1:0]    r_pre;
  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_wrap;
  logic             r_running;
  logic             r_paused;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= IDLE;
      r_pre     <= '0;
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (bus.rst) begin
        r_phase   <= IDLE;
        r_pre     <= '0;
        r_count   <= '0;
        r_running <= 1'b0;
        r_paused  <= 1'b0;
      end else begin
        case (r_phase)
          IDLE, PAUSE: begin
            if (bus.en) begin
              r_phase   <= RUN;
              r_running <= 1'b1;
              r_paused  <= 1'b0;
            end
          end
          RUN: begin
            if (!bus.en) begin
              r_phase   <= PAUSE;
              r_running <= 1'b0;
              r_paused  <= 1'b1;
            end
          end
          default: begin
            r_phase   <= IDLE;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
          end
        endcase

        if (bus.en) begin
          if (r_pre == PRE_LAST) begin
            r_pre <= '0;
`ifdef STEP_SEQUENCER_SATURATE_EN
            // Once parked at MAX, further steps are silent.
            if (r_count != CNT_MAX) begin
              r_count <= r_count + 1'b1;
              r_tick  <= 1'b1;
              r_wrap  <= (r_count == CNT_MAX - 1'b1);
            end
`else
            r_tick <= 1'b1;
            if (r_count == CNT_MAX) begin
              r_count <= '0;
              r_wrap  <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
`endif
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;
  assign bus.running = r_running;
  assign bus.paused  = r_paused;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of step_sequencer in three configurations
// sharing one rst/en stimulus stream:
//   u4  DIV=4 MAX=9, u1  DIV=1 MAX=9, u3  DIV=1 MAX=3.
module tb_step_sequencer;
  logic clk;
  logic reset;
  logic r_rst;
  logic r_en;

  int unsigned n_tests;
  int unsigned n_fail;

  step_sequencer_if #(.CNT_W(8)) if4 ();
  step_sequencer_if #(.CNT_W(8)) if1 ();
  step_sequencer_if #(.CNT_W(8)) if3 ();

  assign if4.rst = r_rst;
  assign if4.en  = r_en;
  assign if1.rst = r_rst;
  assign if1.en  = r_en;
  assign if3.rst = r_rst;
  assign if3.en  = r_en;

  step_sequencer #(.CNT_W(8), .MAX(9), .DIV(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
  step_sequencer #(.CNT_W(8), .MAX(9), .DIV(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  step_sequencer #(.CNT_W(8), .MAX(3), .DIV(1)) u3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply current inputs at the next rising edge, then settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    r_rst = 1'b1;
    r_en  = 1'b0;
    cyc();
    r_rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    r_rst   = 1'b0;
    r_en    = 1'b1;

    // Reset held two cycles with en=1: nothing moves.
    cyc();
    cyc();
    check("rst_count4", 32'(if4.count), 0);
    check("rst_count1", 32'(if1.count), 0);
    check("rst_tick",   32'(if1.tick), 0);
    check("rst_wrap",   32'(if4.wrap), 0);
    check("rst_run",    32'(if4.running), 0);
    check("rst_pause",  32'(if4.paused), 0);
    reset = 1'b0;

    // Basic stepping, DIV=4: ticks after enabled cycles 4, 8, 12.
    clear();
    r_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("basic_tick%0d", k), 32'(if4.tick), (k % 4 == 0) ? 1 : 0);
    end
    check("basic_count", 32'(if4.count), 3);
    check("basic_run",   32'(if4.running), 1);
    check("basic_count_div1", 32'(if1.count), 2);

    // Wrap, DIV=1, MAX=9: count 1..9 then 0, wrap only on 9->0.
    clear();
    check("wrap_idle", 32'(if1.running), 0);
    r_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("wrap_count%0d", k), 32'(if1.count), 32'(k % 10));
      check($sformatf("wrap_pulse%0d", k), 32'(if1.wrap), (k == 10) ? 1 : 0);
    end

    // Pause/resume, DIV=4: partial prescale survives the pause.
    clear();
    r_en = 1'b1;
    cyc();
    cyc();
    r_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("pause_flag%0d", k), 32'(if4.paused), 1);
      check($sformatf("pause_count%0d", k), 32'(if4.count), 0);
    end
    r_en = 1'b1;
    cyc();
    check("resume_tick_a", 32'(if4.tick), 0);
    check("resume_run", 32'(if4.running), 1);
    cyc();
    check("resume_tick_b", 32'(if4.tick), 1);
    check("resume_count", 32'(if4.count), 1);

    // Clear priority: rst with en at count=5 clears without stepping.
    clear();
    r_en = 1'b1;
    for (int k = 1; k <= 20; k++) cyc();
    check("prio_pre_count", 32'(if4.count), 5);
    check("prio_pre_tick",  32'(if4.tick), 1);
    r_rst = 1'b1;
    cyc();
    check("prio_count", 32'(if4.count), 0);
    check("prio_tick",  32'(if4.tick), 0);
    check("prio_run",   32'(if4.running), 0);
    check("prio_pause", 32'(if4.paused), 0);
    r_rst = 1'b0;
    cyc();
    check("prio_rerun", 32'(if4.running), 1);
    check("prio_hold",  32'(if4.count), 0);

    // Reset mid-step: prescaler at DIV-1 when reset hits; step discarded.
    clear();
    r_en = 1'b1;
    for (int k = 1; k <= 7; k++) cyc();
    check("mid_pre_count", 32'(if4.count), 1);
    reset = 1'b1;
    cyc();
    check("mid_count", 32'(if4.count), 0);
    check("mid_tick",  32'(if4.tick), 0);
    check("mid_run",   32'(if4.running), 0);
    reset = 1'b0;

    // MAX=3, DIV=1: saturation or wrap depending on build.
    clear();
    r_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
`ifdef STEP_SEQUENCER_SATURATE_EN
      check($sformatf("sat_count%0d", k), 32'(if3.count), (k < 3) ? 32'(k) : 3);
      check($sformatf("sat_wrap%0d", k),  32'(if3.wrap),  (k == 3) ? 1 : 0);
      check($sformatf("sat_tick%0d", k),  32'(if3.tick),  (k <= 3) ? 1 : 0);
`else
      check($sformatf("m3_count%0d", k), 32'(if3.count), 32'(k % 4));
      check($sformatf("m3_wrap%0d", k),  32'(if3.wrap),  (k == 4) ? 1 : 0);
      check($sformatf("m3_tick%0d", k),  32'(if3.tick),  1);
`endif
    end
    clear();
    check("m3_clear", 32'(if3.count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Datapath end of the run-control interface: consumes the `rst`/`en` command pair from the run-control FSM and advances a step counter.
- A prescaler divides enabled cycles into steps. The counter wraps at a programmable terminal value.
- Reports phase (idle/run/pause), a per-step tick and a wrap pulse back to the controller and downstream logic.

Parameters:
- CNT_W, 8, step counter width.
- MAX, 255, terminal count value; legal range 1..2^CNT_W-1.
- DIV, 4, enabled cycles per step; legal range >=1. Prescaler width is max(1, clog2(DIV)).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rst  in  1  soft clear command from the run-control FSM.
- en  in  1  advance enable from the run-control FSM.
- count  out  CNT_W  current step value.
- tick  out  1  one-cycle pulse on each step.
- wrap  out  1  one-cycle pulse when count goes MAX->0.
- running  out  1  phase == RUN.
- paused  out  1  phase == PAUSE.

Behaviour:
- Reset (reset=1 at a clk edge):
  - phase=IDLE, count=0, prescaler=0.
  - tick=0, wrap=0, running=0, paused=0.
  - reset overrides rst and en.
- Priority per cycle: reset > rst > en.
- Phase FSM; all outputs are registered and valid the cycle after the causing input.
  - IDLE: rst=1 -> IDLE; else en=1 -> RUN; else stay IDLE.
  - RUN: rst=1 -> IDLE; else en=0 -> PAUSE; else stay RUN.
  - PAUSE: rst=1 -> IDLE; else en=1 -> RUN; else stay PAUSE.
- Soft clear: rst=1 clears count and prescaler and forces tick=0, wrap=0 next cycle, in any phase. rst=1 with en=1 clears; it does not advance.
- Prescaler:
  - Increments on every cycle with en=1 and rst=0.
  - On an enabled cycle with prescaler==DIV-1: prescaler<=0 and a step occurs.
  - en=0 holds the prescaler; pause/resume does not lose partial progress.
- Step:
  - count<=count+1, or 0 if count==MAX.
  - tick=1 the following cycle.
  - wrap=1 the following cycle, only when count was MAX.
  - tick and wrap are 0 on all other cycles.
- Latency: the first step occurs on the DIV-th enabled cycle after a clear. count, tick and wrap reflect it one cycle later.
- DIV=1: a step occurs on every enabled cycle.
- Arithmetic is unsigned. No value outside 0..MAX is ever stored.
- en toggling mid-prescale: only cycles with en=1 are counted.
- reset asserted mid-step: the step is discarded and all state goes to reset values next cycle.

Optional Feature:
- Macro: STEP_SEQUENCER_SATURATE_EN.
- Defined:
  - A step at count==MAX holds count at MAX instead of wrapping.
  - wrap pulses once on the first arrival at MAX; tick still pulses on every step.
  - A further step while count==MAX produces neither tick nor wrap.
  - Only rst or reset release saturation.
- Undefined: wrap-around behaviour as described above.

Test Plan:
- Reset with DIV=4: hold reset 2 cycles with en=1 -> count=0, tick=0, wrap=0, running=0, paused=0; with reset high the whole time, no step occurs.
- Basic stepping, DIV=4, MAX=9: rst pulse, then en=1 for 12 cycles -> ticks after enabled cycles 4, 8, 12; count=3; running=1.
- Wrap, DIV=1, MAX=9: en=1 for 10 cycles from clear -> count 1..9 then 0; wrap=1 exactly once, coinciding with count 9->0.
- Pause/resume, DIV=4: en=1 for 2 cycles, en=0 for 5 (paused=1, count=0), en=1 for 2 more -> one tick, count=1.
- Clear priority: rst=1 and en=1 together while count=5 -> count=0, phase IDLE, no tick. Then en=1 -> running=1 next cycle.
- Saturation, with STEP_SEQUENCER_SATURATE_EN, DIV=1, MAX=3: en=1 for 6 cycles -> count 1, 2, 3, 3, 3, 3; wrap once; 3 ticks. Then rst -> count=0.
